// File: rtl/bus_port_fifo_if.sv
// Device/bus handshake bundle for one bus_port_fifo instance.
// slave is the port itself, master is whoever drives it.
interface bus_port_fifo_if #(
   parameter int PCKG_SZ = 16,
   parameter int DEPTH   = 12
);
   localparam int CW = $clog2(DEPTH + 1);

   logic               dev_push;
   logic [PCKG_SZ-1:0] dev_din;
   logic               tx_full;
   logic [CW-1:0]      tx_count;
   logic               pndng;
   logic               pop;
   logic [PCKG_SZ-1:0] D_pop;
   logic               push;
   logic [PCKG_SZ-1:0] D_push;
   logic               dev_pop;
   logic [PCKG_SZ-1:0] dev_dout;
   logic               rx_pndng;
   logic [CW-1:0]      rx_count;
   logic [15:0]        drop_cnt;
   logic [15:0]        misaddr_cnt;
   logic               err;

   modport slave (
      input  dev_push, dev_din, pop,
      input  push, D_push, dev_pop,
      output tx_full, tx_count, pndng,
      output D_pop, dev_dout, rx_pndng,
      output rx_count, drop_cnt,
      output misaddr_cnt, err
   );

   modport master (
      output dev_push, dev_din, pop,
      output push, D_push, dev_pop,
      input  tx_full, tx_count, pndng,
      input  D_pop, dev_dout, rx_pndng,
      input  rx_count, drop_cnt,
      input  misaddr_cnt, err
   );
endinterface

// File: rtl/bus_port_fifo.sv
// Per-device bus port: FWFT TX FIFO toward the arbiter and an
// address-filtered FWFT RX FIFO toward the device.
module bus_port_fifo #(
   parameter int          PCKG_SZ   = 16,
   parameter int          DEPTH     = 12,
   parameter logic [7:0]  ID        = 8'd0,
   parameter logic [7:0]  BROADCAST = 8'hFF
) (
   input  logic           clk,
   input  logic           reset,
   bus_port_fifo_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CFULL = CW'(DEPTH);

   function automatic logic [PW-1:0] nxt(
      input logic [PW-1:0] p
   );
      return (p == PLAST) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [15:0] sat_inc(
      input logic [15:0] c
   );
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   logic [PCKG_SZ-1:0] tx_mem [DEPTH];
   logic [PCKG_SZ-1:0] rx_mem [DEPTH];

   logic [PW-1:0] tx_wr_q, tx_wr_d;
   logic [PW-1:0] tx_rd_q, tx_rd_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [PW-1:0] rx_wr_q, rx_wr_d;
   logic [PW-1:0] rx_rd_q, rx_rd_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [15:0]   drop_q, drop_d;
   logic [15:0]   mis_q, mis_d;
   logic          err_q, err_d;

   logic tx_empty, tx_full;
   logic rx_empty, rx_full;
   logic tx_we, tx_re;
   logic rx_we, rx_re;
   logic [7:0] dst;
   logic addr_hit;
   logic accept;

   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == CFULL);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == CFULL);

   assign dst      = bus.D_push[PCKG_SZ-1 -: 8];
   assign addr_hit = (dst == ID) || (dst == BROADCAST);
   assign accept   = bus.push && addr_hit;

   // A pop frees a slot in the same cycle, so a full FIFO still writes.
   assign tx_re = bus.pop && !tx_empty;
   assign tx_we = bus.dev_push && (!tx_full || bus.pop);
   assign rx_re = bus.dev_pop && !rx_empty;
   assign rx_we = accept && (!rx_full || bus.dev_pop);

   always_comb begin
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_we) tx_wr_d = nxt(tx_wr_q);
      if (tx_re) tx_rd_d = nxt(tx_rd_q);
      if (tx_we && !tx_re)
         tx_cnt_d = tx_cnt_q + CW'(1);
      else if (!tx_we && tx_re)
         tx_cnt_d = tx_cnt_q - CW'(1);
   end

   always_comb begin
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_we) rx_wr_d = nxt(rx_wr_q);
      if (rx_re) rx_rd_d = nxt(rx_rd_q);
      if (rx_we && !rx_re)
         rx_cnt_d = rx_cnt_q + CW'(1);
      else if (!rx_we && rx_re)
         rx_cnt_d = rx_cnt_q - CW'(1);
   end

   // RX overflow only bumps drop_cnt: the bus cannot be stalled.
   always_comb begin
      drop_d = drop_q;
      mis_d  = mis_q;
      err_d  = err_q;
      if (bus.push && !addr_hit)
         mis_d = sat_inc(mis_q);
      if (accept && rx_full && !bus.dev_pop)
         drop_d = sat_inc(drop_q);
      if (bus.dev_push && tx_full && !bus.pop)
         err_d = 1'b1;
      if (bus.pop && tx_empty)
         err_d = 1'b1;
      if (bus.dev_pop && rx_empty)
         err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
         drop_q   <= '0;
         mis_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         rx_cnt_q <= rx_cnt_d;
         drop_q   <= drop_d;
         mis_q    <= mis_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_we) tx_mem[tx_wr_q] <= bus.dev_din;
      if (rx_we) rx_mem[rx_wr_q] <= bus.D_push;
   end

   assign bus.tx_full     = tx_full;
   assign bus.tx_count    = tx_cnt_q;
   assign bus.pndng       = !tx_empty;
   assign bus.D_pop       = tx_empty ? '0 : tx_mem[tx_rd_q];
   assign bus.rx_pndng    = !rx_empty;
   assign bus.rx_count    = rx_cnt_q;
   assign bus.dev_dout    = rx_empty ? '0 : rx_mem[rx_rd_q];
   assign bus.drop_cnt    = drop_q;
   assign bus.misaddr_cnt = mis_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed self-checking bench for bus_port_fifo
// (PCKG_SZ=16, DEPTH=12, ID=3).
module tb_bus_port_fifo;
   logic clk;
   logic reset;
   int   n_run;
   int   n_fail;

   bus_port_fifo_if #(.PCKG_SZ(16), .DEPTH(12)) bif ();

   bus_port_fifo #(
      .PCKG_SZ  (16),
      .DEPTH    (12),
      .ID       (8'd3),
      .BROADCAST(8'hFF)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bif.dev_push = 1'b0;
      bif.dev_din  = '0;
      bif.pop      = 1'b0;
      bif.push     = 1'b0;
      bif.D_push   = '0;
      bif.dev_pop  = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_pndng"},  32'(bif.pndng), 0);
      chk({pfx, "_rxp"},    32'(bif.rx_pndng), 0);
      chk({pfx, "_full"},   32'(bif.tx_full), 0);
      chk({pfx, "_txc"},    32'(bif.tx_count), 0);
      chk({pfx, "_rxc"},    32'(bif.rx_count), 0);
      chk({pfx, "_dpop"},   32'(bif.D_pop), 0);
      chk({pfx, "_dout"},   32'(bif.dev_dout), 0);
      chk({pfx, "_drop"},   32'(bif.drop_cnt), 0);
      chk({pfx, "_mis"},    32'(bif.misaddr_cnt), 0);
      chk({pfx, "_err"},    32'(bif.err), 0);
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      idle();
      reset = 1'b0;
      tick();
      tick();
      chk_zero("rst");
      reset = 1'b1;
      tick();

      // TX basic FWFT
      bif.dev_push = 1'b1;
      bif.dev_din  = 16'h0A11;
      tick();
      chk("tx1_pndng", 32'(bif.pndng), 1);
      chk("tx1_head", 32'(bif.D_pop), 32'h0A11);
      bif.dev_din = 16'h0A22;
      tick();
      bif.dev_din = 16'h0A33;
      tick();
      idle();
      chk("tx3_cnt", 32'(bif.tx_count), 3);
      chk("tx3_head", 32'(bif.D_pop), 32'h0A11);
      bif.pop = 1'b1;
      tick();
      chk("pop1_head", 32'(bif.D_pop), 32'h0A22);
      tick();
      chk("pop2_head", 32'(bif.D_pop), 32'h0A33);
      tick();
      bif.pop = 1'b0;
      chk("pop3_head", 32'(bif.D_pop), 0);
      chk("pop3_pndng", 32'(bif.pndng), 0);
      chk("pop3_err", 32'(bif.err), 0);

      // RX address filter
      bif.push   = 1'b1;
      bif.D_push = 16'h03AB;
      tick();
      bif.D_push = 16'hFF01;
      tick();
      bif.D_push = 16'h0500;
      tick();
      idle();
      chk("rxf_cnt", 32'(bif.rx_count), 2);
      chk("rxf_mis", 32'(bif.misaddr_cnt), 1);
      chk("rxf_pnd", 32'(bif.rx_pndng), 1);
      chk("rxf_head", 32'(bif.dev_dout), 32'h03AB);
      bif.dev_pop = 1'b1;
      tick();
      chk("rxf_head2", 32'(bif.dev_dout), 32'hFF01);
      chk("rxf_cnt2", 32'(bif.rx_count), 1);
      tick();
      bif.dev_pop = 1'b0;
      chk("rxf_empty", 32'(bif.dev_dout), 0);
      chk("rxf_pnd0", 32'(bif.rx_pndng), 0);

      // RX fill, drop, pop-while-full
      bif.push = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bif.D_push = 16'h0300 + 16'(i);
         tick();
      end
      chk("rxfill_cnt", 32'(bif.rx_count), 12);
      bif.D_push = 16'h0390;
      tick();
      bif.D_push = 16'h0391;
      tick();
      chk("rxdrop_cnt", 32'(bif.drop_cnt), 2);
      chk("rxdrop_rxc", 32'(bif.rx_count), 12);
      chk("rxdrop_err", 32'(bif.err), 0);
      bif.D_push  = 16'h0392;
      bif.dev_pop = 1'b1;
      tick();
      idle();
      chk("rxfp_drop", 32'(bif.drop_cnt), 2);
      chk("rxfp_cnt", 32'(bif.rx_count), 12);
      bif.dev_pop = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         chk($sformatf("rxdrain%0d", i),
             32'(bif.dev_dout),
             (i == 12) ? 32'h0392 : 32'h0300 + i);
         tick();
      end
      bif.dev_pop = 1'b0;
      chk("rxdrain_cnt", 32'(bif.rx_count), 0);
      chk("rxdrain_mis", 32'(bif.misaddr_cnt), 1);
      chk("rxdrain_err", 32'(bif.err), 0);

      // TX full, overflow, push+pop across wrap
      bif.dev_push = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bif.dev_din = 16'h1000 + 16'(i);
         tick();
      end
      chk("txfull_f", 32'(bif.tx_full), 1);
      chk("txfull_c", 32'(bif.tx_count), 12);
      bif.dev_din = 16'h1FFF;
      tick();
      chk("txovf_err", 32'(bif.err), 1);
      chk("txovf_cnt", 32'(bif.tx_count), 12);
      chk("txovf_head", 32'(bif.D_pop), 32'h1000);
      bif.dev_din = 16'h100C;
      bif.pop     = 1'b1;
      tick();
      bif.dev_push = 1'b0;
      chk("txpp_cnt", 32'(bif.tx_count), 12);
      for (int i = 1; i <= 12; i++) begin
         chk($sformatf("txdrain%0d", i),
             32'(bif.D_pop), 32'h1000 + i);
         tick();
      end
      bif.pop = 1'b0;
      chk("txdrain_cnt", 32'(bif.tx_count), 0);
      chk("txdrain_pnd", 32'(bif.pndng), 0);

      // Underflow handling
      do_reset();
      chk("rst2_err", 32'(bif.err), 0);
      bif.pop = 1'b1;
      tick();
      idle();
      chk("txund_err", 32'(bif.err), 1);
      chk("txund_cnt", 32'(bif.tx_count), 0);
      do_reset();
      bif.dev_pop = 1'b1;
      tick();
      idle();
      chk("rxund_err", 32'(bif.err), 1);
      chk("rxund_cnt", 32'(bif.rx_count), 0);
      bif.dev_push = 1'b1;
      bif.dev_din  = 16'h0ABC;
      bif.pop      = 1'b1;
      tick();
      idle();
      chk("pp_empty_cnt", 32'(bif.tx_count), 1);
      chk("pp_empty_head", 32'(bif.D_pop), 32'h0ABC);

      // Asynchronous reset mid-burst
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bif.dev_push = 1'b1;
         bif.dev_din  = 16'h2000 + 16'(i);
         bif.push     = 1'b1;
         bif.D_push   = (i < 4) ? 16'h0310 + 16'(i)
                                : 16'h0700;
         tick();
      end
      idle();
      bif.pop = 1'b1;
      tick();
      bif.pop = 1'b1;
      tick();
      bif.dev_push = 1'b1;
      bif.dev_din  = 16'h2005;
      bif.pop      = 1'b0;
      tick();
      bif.dev_push = 1'b1;
      bif.dev_din  = 16'h2006;
      tick();
      idle();
      chk("burst_txc", 32'(bif.tx_count), 5);
      chk("burst_rxc", 32'(bif.rx_count), 4);
      chk("burst_mis", 32'(bif.misaddr_cnt), 1);
      bif.dev_pop = 1'b1;
      tick();
      chk("burst_err", 32'(bif.err), 0);
      bif.dev_pop = 1'b0;
      bif.pop     = 1'b1;
      bif.dev_push = 1'b1;
      bif.dev_din  = 16'h2007;
      #2;
      reset = 1'b0;
      #1;
      chk_zero("arst");
      tick();
      idle();
      chk_zero("arst_hold");
      reset = 1'b1;
      tick();
      bif.dev_push = 1'b1;
      bif.dev_din  = 16'h0A55;
      tick();
      idle();
      chk("post_cnt", 32'(bif.tx_count), 1);
      chk("post_head", 32'(bif.D_pop), 32'h0A55);
      chk("post_rxc", 32'(bif.rx_count), 0);

      $display("[TB] %0d tests run, %0d failed",
               n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=done");
      $fatal(1);
   end
endmodule
